// File: rtl/cpu_pkg.sv
// Shared CPU constants: word widths, instruction field positions and fetch FSM states.
package cpu_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 16;

  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 11;
  localparam int unsigned FLAG_BIT = 10;
  localparam int unsigned IMM_MSB  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface fetch_unit_if #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter with sequential/target next-PC select and a wrapping +2 adder.
module fetch_unit_pc_reg #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              advance_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus2_o
);

  logic [ADDR_W-1:0] pc_d, pc_q;

  assign pc_o       = pc_q;
  assign pc_plus2_o = pc_q + ADDR_W'(2);

  always_comb begin
    pc_d = pc_q;
    if (advance_i) begin
      // Targets are halfword aligned by dropping bit 0; no misalignment trap.
      pc_d = redirect_i ? (target_i & ~ADDR_W'(1)) : pc_plus2_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: imem handshake, instruction register, decode outputs and retire counter.
module fetch_unit #(
  parameter int unsigned       DATA_W   = cpu_pkg::DATA_W,
  parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned       IMM_W    = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  fetch_unit_if.master      imem,
  output logic [4:0]        OPCODE,
  output logic              flagbit,
  output logic [DATA_W-1:0] imm_ext,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              PCWrite,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] pc_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus2,
  output logic [15:0]       retired
);

  import cpu_pkg::*;

  fetch_state_e      state_d, state_q;
  logic [DATA_W-1:0] ir_d, ir_q;
  logic [15:0]       retired_d, retired_q;
  logic              retire;

  assign retire = (state_q == HOLD) && exec_done;

  fetch_unit_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i      (CLK),
    .rst_i      (Reset),
    .advance_i  (retire),
    .redirect_i (PCWrite && PCSrc),
    .target_i   (pc_target),
    .pc_o       (pc),
    .pc_plus2_o (pc_plus2)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem.imem_ready) begin
          ir_d    = imem.imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // exec_done wins over a coincident imem_ready; no overlapped fetch.
        if (exec_done) begin
          retired_d = retired_q + 16'd1;
          state_d   = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc;
  assign instr_valid    = (state_q == HOLD);
  assign retired        = retired_q;

  // Decode reads as zero unless a live instruction is held.
  always_comb begin
    OPCODE  = '0;
    flagbit = 1'b0;
    imm_ext = '0;
    if (instr_valid) begin
      OPCODE  = ir_q[OP_MSB:OP_LSB];
      flagbit = ir_q[FLAG_BIT];
      imm_ext = {{(DATA_W - IMM_W){ir_q[IMM_MSB]}}, ir_q[IMM_W-1:0]};
    end
  end

endmodule
